// File: rtl/wb_config_bridge_if.sv
// Bus bundle between the Wishbone management port and the config-bus responders.
// The slave modport is the bridge side, the master modport the SoC/responder side.
interface wb_config_bridge_if;
    localparam int unsigned WB_DW  = 32;
    localparam int unsigned WB_AW  = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CFG_AW = 24;

    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [SEL_W-1:0]  wbs_sel_i;
    logic [WB_AW-1:0]  wbs_adr_i;
    logic [WB_DW-1:0]  wbs_dat_i;
    logic              wbs_ack_o;
    logic [WB_DW-1:0]  wbs_dat_o;

    logic              config_we;
    logic              config_oe;
    logic [CFG_AW-1:0] config_address;
    logic [SEL_W-1:0]  config_sel;
    logic [WB_DW-1:0]  config_data_write;
    logic [WB_DW-1:0]  config_data_read;
    logic              config_busy;
    logic              config_timeout;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  config_data_read, config_busy,
        output wbs_ack_o, wbs_dat_o,
        output config_we, config_oe, config_address, config_sel, config_data_write,
        output config_timeout
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output config_data_read, config_busy,
        input  wbs_ack_o, wbs_dat_o,
        input  config_we, config_oe, config_address, config_sel, config_data_write,
        input  config_timeout
    );
endinterface

// File: rtl/wb_config_bridge.sv
// Wishbone classic responder turning single reads/writes into config-bus
// strobe transactions with wait-state support.
// Optional feature macro: CONFIG_BRIDGE_TIMEOUT_EN (abort transfers whose
// responder stays busy for TIMEOUT_CYCLES wait cycles).
module wb_config_bridge #(
    parameter logic [31:0] ADDRESS_BASE   = 32'h3000_0000,
    parameter logic [31:0] ADDRESS_MASK   = 32'hFF00_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_config_bridge_if.slave bus
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CAW   = 24;
    localparam int unsigned SW    = 4;
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t         state_q, state_d;
    logic [CAW-1:0] addr_q, addr_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [DW-1:0]  wdat_q, wdat_d;
    logic           we_q, we_d;
    logic           lost_q, lost_d;
    logic           cfg_we_q, cfg_we_d;
    logic           cfg_oe_q, cfg_oe_d;
    logic           ack_q, ack_d;
    logic [DW-1:0]  rdat_q, rdat_d;
    logic           tmo_q, tmo_d;
    logic           hit_c;
    logic           lost_c;
    logic           expired_c;

    // Window decode and "master abandoned the cycle" tracking
    assign hit_c  = (bus.wbs_adr_i & ADDRESS_MASK) == ADDRESS_BASE;
    assign lost_c = lost_q | ~bus.wbs_cyc_i;

`ifdef CONFIG_BRIDGE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;

    // Saturating wait-state counter, cleared whenever the bridge is idle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (state_q != ACCESS) begin
            cnt_q <= '0;
        end else if (bus.config_busy && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = cnt_q >= TIMEOUT_LIMIT;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^CNT_W'(TIMEOUT_CYCLES);
    assign expired_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sel_q    <= '0;
            wdat_q   <= '0;
            we_q     <= 1'b0;
            lost_q   <= 1'b0;
            cfg_we_q <= 1'b0;
            cfg_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            we_q     <= we_d;
            lost_q   <= lost_d;
            cfg_we_q <= cfg_we_d;
            cfg_oe_q <= cfg_oe_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        we_d     = we_q;
        lost_d   = lost_q;
        cfg_we_d = 1'b0;
        cfg_oe_d = 1'b0;
        ack_d    = 1'b0;
        rdat_d   = '0;
        tmo_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i && hit_c) begin
                    state_d  = ACCESS;
                    addr_d   = bus.wbs_adr_i[CAW-1:0];
                    sel_d    = bus.wbs_sel_i;
                    wdat_d   = bus.wbs_dat_i;
                    we_d     = bus.wbs_we_i;
                    lost_d   = 1'b0;
                    cfg_we_d = bus.wbs_we_i;
                    cfg_oe_d = ~bus.wbs_we_i;
                end
            end
            ACCESS: begin
                lost_d = lost_c;
                if (!bus.config_busy || expired_c) begin
                    state_d = RESPOND;
                    ack_d   = ~lost_c;
                    tmo_d   = bus.config_busy & expired_c;
                    if (lost_c) begin
                        rdat_d = '0;
                    end else if (bus.config_busy) begin
                        rdat_d = '1;
                    end else if (!we_q) begin
                        rdat_d = bus.config_data_read;
                    end
                end else begin
                    cfg_we_d = we_q;
                    cfg_oe_d = ~we_q;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wbs_ack_o         = ack_q;
    assign bus.wbs_dat_o         = rdat_q;
    assign bus.config_we         = cfg_we_q;
    assign bus.config_oe         = cfg_oe_q;
    assign bus.config_address    = addr_q;
    assign bus.config_sel        = sel_q;
    assign bus.config_data_write = wdat_q;
    assign bus.config_timeout    = tmo_q;
endmodule

// File: tb/tb_wb_config_bridge.sv
// Directed plus randomized bench for wb_config_bridge; expectations come from
// the bridge's transaction rules (window hit, wait count, read/write data).
module tb_wb_config_bridge;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFF00_0000;
`ifdef CONFIG_BRIDGE_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle_no = 0;
    int   s1, s2, sx;

    wb_config_bridge_if bus();

    wb_config_bridge #(
        .ADDRESS_BASE  (BASE),
        .ADDRESS_MASK  (MASK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer with a responder that holds busy for `waits` strobe
    // cycles (or forever when `stuck`); expectations follow the bridge rules.
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wdat, input logic [31:0] rdat, input int waits,
                          input bit stuck, input int drop_at, input bit hold,
                          output int strobe_start);
        bit          in_win;
        bit          exp_ack;
        int          exp_strobes;
        int          limit;
        int          cycles;
        int          strobes;
        int          acks;
        int          ack_at;
        logic [31:0] exp_dat;

        in_win = ((adr & MASK) == BASE);
        if (!in_win) begin
            exp_strobes = 0;
            exp_ack     = 1'b0;
            limit       = 20;
        end else if (stuck && !TEN) begin
            exp_strobes = 1000;
            exp_ack     = 1'b0;
            limit       = 1000;
        end else begin
            exp_strobes = stuck ? TO + 1 : waits + 1;
            exp_ack     = (drop_at == 0);
            limit       = exp_strobes + 10;
        end
        exp_dat = stuck ? 32'hFFFF_FFFF : (we ? 32'h0 : rdat);

        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.config_busy      = stuck || (waits > 0);
        bus.config_data_read = bus.config_busy ? ~rdat : rdat;
        cycles = 0; strobes = 0; acks = 0; ack_at = 0; strobe_start = 0;

        while (cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.config_we || bus.config_oe) begin
                strobes++;
                if (strobes == 1) strobe_start = cycle_no;
                check("strobe_we", 32'(bus.config_we), 32'(we));
                check("strobe_oe", 32'(bus.config_oe), 32'(!we));
                check("cfg_addr", 32'(bus.config_address), {8'h0, adr[23:0]});
                check("cfg_sel", 32'(bus.config_sel), 32'(sel));
                if (we) check("cfg_wdata", bus.config_data_write, wdat);
                bus.config_busy      = stuck || (strobes <= waits);
                bus.config_data_read = bus.config_busy ? ~rdat : rdat;
                if (drop_at != 0 && strobes == drop_at) begin
                    bus.wbs_cyc_i = 1'b0;
                    bus.wbs_stb_i = 1'b0;
                end
            end
            if (bus.wbs_ack_o) begin
                acks++;
                ack_at = cycles;
                check("ack_dat", bus.wbs_dat_o, exp_dat);
                check("ack_timeout", 32'(bus.config_timeout), 32'(stuck));
                break;
            end else begin
                check("idle_dat", bus.wbs_dat_o, 32'h0);
                check("idle_timeout", 32'(bus.config_timeout), 32'h0);
            end
        end

        check("strobe_cycles", 32'(strobes), 32'(exp_strobes));
        check("ack_count", 32'(acks), 32'(exp_ack));
        if (exp_ack) begin
            check("ack_latency", 32'(ack_at), 32'(exp_strobes + 1));
            @(posedge clk); #1;
            check("ack_single", 32'(bus.wbs_ack_o), 32'h0);
            check("dat_after_ack", bus.wbs_dat_o, 32'h0);
        end
        if (!(hold && exp_ack)) begin
            bus.wbs_cyc_i = 1'b0;
            bus.wbs_stb_i = 1'b0;
        end
        bus.config_busy = 1'b0;
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        bus.config_data_read = 32'h0;
        bus.config_busy      = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("rst_we", 32'(bus.config_we), 32'h0);
        check("rst_oe", 32'(bus.config_oe), 32'h0);
        check("rst_timeout", 32'(bus.config_timeout), 32'h0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_addr", 32'(bus.config_address), 32'h0);
        check("rst_sel", 32'(bus.config_sel), 32'h0);
        check("rst_wdata", bus.config_data_write, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write, waited read, out-of-window write
        do_txn(32'h3000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 0, 1'b0, sx);
        do_txn(32'h3000_0004, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 3, 1'b0, 0, 1'b0, sx);
        do_txn(32'h2000_0000, 1'b1, 4'hF, 32'h5555_AAAA, 32'h0, 0, 1'b0, 0, 1'b0, sx);

        // Back-to-back writes: second strobe three cycles after the first
        do_txn(32'h3000_0020, 1'b1, 4'h3, 32'h0000_1111, 32'h0, 0, 1'b0, 0, 1'b1, s1);
        do_txn(32'h3000_0024, 1'b1, 4'hC, 32'h2222_0000, 32'h0, 0, 1'b0, 0, 1'b0, s2);
        check("b2b_spacing", 32'(s2 - s1), 32'd3);

        // Master drops cyc mid-access: access completes, no ack
        do_txn(32'h3000_0030, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1, 1'b0, sx);

        // Responder stuck busy
        do_txn(32'h3000_0040, 1'b0, 4'hF, 32'h0, 32'h0BAD_0BAD, 0, 1'b1, 0, 1'b0, sx);
        repeat (3) begin
            @(posedge clk); #1;
            check("post_stuck_ack", 32'(bus.wbs_ack_o), 32'h0);
        end

        // Reset while waiting in the access phase
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h3000_0008;
        bus.config_busy = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_oe", 32'(bus.config_oe), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_oe", 32'(bus.config_oe), 32'h0);
        check("rst_mid_we", 32'(bus.config_we), 32'h0);
        check("rst_mid_ack", 32'(bus.wbs_ack_o), 32'h0);
        rst = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.config_busy = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
            check("post_rst_oe", 32'(bus.config_oe), 32'h0);
        end
        do_txn(32'h3000_0050, 1'b1, 4'h1, 32'h0000_00A5, 32'h0, 1, 1'b0, 0, 1'b0, sx);

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = BASE | (a & 32'h00FF_FFFF);
            do_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), 1'b0, 0, 1'($urandom), sx);
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
